// File: rtl/jk_excite_driver_pkg.sv
// Shared types and helpers for the JK excitation driver: output-stage FSM
// states, don't-care fill encodings and the JK flip-flop next-state function.
package jk_excite_driver_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  localparam int DC_FILL_ZERO = 0;
  localparam int DC_FILL_ONE  = 1;

  // {j,k}: 00 hold, 01 clear, 10 set, 11 toggle
  function automatic logic jk_next(input logic q, input logic j, input logic k);
    logic nq;
    case ({j, k})
      2'b00:   nq = q;
      2'b01:   nq = 1'b0;
      2'b10:   nq = 1'b1;
      default: nq = ~q;
    endcase
    return nq;
  endfunction

endpackage

// File: rtl/jk_model_cell.sv
// One bit of the modelled JK register: load beats the JK update, reset beats both.
// q_adv is the post-update value (before any load), used as the excitation basis.
module jk_model_cell
  import jk_excite_driver_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic load,
  input  logic load_val,
  input  logic j,
  input  logic k,
  output logic q,
  output logic q_adv
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_adv = en ? jk_next(q_q, j, k) : q_q;
    q_d   = load ? load_val : q_adv;
  end

  always_ff @(posedge clk) begin
    if (rst) q_q <= 1'b0;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/jk_excite_driver.sv
// Converts target register values into J/K excitation vectors against a local
// model of the JK register, with a one-entry valid/ready output stage.
module jk_excite_driver
  import jk_excite_driver_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DC_POLICY = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           tgt_data,
  input  logic                       tgt_valid,
  output logic                       tgt_ready,
  input  logic [WIDTH-1:0]           sync_data,
  input  logic                       sync_valid,
  output logic [WIDTH-1:0]           j,
  output logic [WIDTH-1:0]           k,
  output logic                       jk_valid,
  input  logic                       jk_ready,
  output logic [WIDTH-1:0]           q_model,
  output logic [$clog2(WIDTH+1)-1:0] chg_cnt,
  output logic [15:0]                xfer_cnt,
  output state_e                     dbg_state
);

  localparam int   CW     = $clog2(WIDTH + 1);
  localparam logic DC_BIT = (DC_POLICY == DC_FILL_ONE);

  // Handshakes: a transfer happens on a cycle where valid && ready are both 1.
  // tgt_ready never depends on tgt_valid; jk_valid never depends on jk_ready.

  state_e           state_q, state_d;
  logic [WIDTH-1:0] j_q, j_d, k_q, k_d;
  logic [CW-1:0]    chg_q, chg_d;
  logic [15:0]      xfer_q, xfer_d;

  logic [WIDTH-1:0] basis;
  logic [WIDTH-1:0] j_new, k_new;
  logic [CW-1:0]    chg_sum;
  logic             hs;
  logic             accept;

  assign hs        = (state_q == ST_FULL) && jk_ready;
  assign tgt_ready = ((state_q == ST_EMPTY) || jk_ready) && !sync_valid && !rst;
  assign accept    = tgt_valid && tgt_ready;

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    jk_model_cell u_cell (
      .clk      (clk),
      .rst      (rst),
      .en       (hs),
      .load     (sync_valid),
      .load_val (sync_data[g]),
      .j        (j_q[g]),
      .k        (k_q[g]),
      .q        (q_model[g]),
      .q_adv    (basis[g])
    );
  end

  // basis already reflects a same-cycle handshake, giving 1 transfer/cycle.
  always_comb begin
    j_new   = '0;
    k_new   = '0;
    chg_sum = '0;
    for (int i = 0; i < WIDTH; i++) begin
      j_new[i] = basis[i] ? DC_BIT : tgt_data[i];
      k_new[i] = basis[i] ? ~tgt_data[i] : DC_BIT;
      chg_sum  = chg_sum + CW'(basis[i] ^ tgt_data[i]);
    end
  end

  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    k_d     = k_q;
    chg_d   = chg_q;
    xfer_d  = xfer_q;
    if (sync_valid) begin
      state_d = ST_EMPTY;
    end else begin
      if (hs) xfer_d = xfer_q + 16'd1;
      if (accept) begin
        state_d = ST_FULL;
        j_d     = j_new;
        k_d     = k_new;
        chg_d   = chg_sum;
      end else if (hs) begin
        state_d = ST_EMPTY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      j_q     <= '0;
      k_q     <= '0;
      chg_q   <= '0;
      xfer_q  <= '0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      k_q     <= k_d;
      chg_q   <= chg_d;
      xfer_q  <= xfer_d;
    end
  end

  assign j         = j_q;
  assign k         = k_q;
  assign jk_valid  = (state_q == ST_FULL);
  assign chg_cnt   = chg_q;
  assign xfer_cnt  = xfer_q;
  assign dbg_state = state_q;

endmodule

// File: doc/jk_excite_driver.md
JK_EXCITE_DRIVER -- requirements
Module: jk_excite_driver

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the number of JK-register bits driven.
REQ-002 The block SHALL have parameter DC_POLICY, default 0, selecting the don't-care fill (0: fill with 0; 1: fill with 1).
REQ-003 The block SHALL have one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 tgt_data  input  WIDTH  desired next value of the JK register.
REQ-006 tgt_valid  input  1  tgt_data is valid.
REQ-007 tgt_ready  output  1  block accepts tgt_data this cycle.
REQ-008 sync_data  input  WIDTH  actual JK-register contents, used for resynchronisation.
REQ-009 sync_valid  input  1  load sync_data into the model.
REQ-010 j  output  WIDTH  J excitation vector.
REQ-011 k  output  WIDTH  K excitation vector.
REQ-012 jk_valid  output  1  j/k are valid.
REQ-013 jk_ready  input  1  consumer applies j/k this cycle.
REQ-014 q_model  output  WIDTH  modelled JK-register state.
REQ-015 chg_cnt  output  clog2(WIDTH+1)  number of bits that change for the presented j/k.
REQ-016 xfer_cnt  output  16  count of completed j/k handshakes.

Function
REQ-017 Per bit, with q as the model bit and t as the target bit, excitation SHALL be: q0->t0: J=0, K=x; 0->1: J=1, K=x; 1->0: J=x, K=1; 1->1: J=x, K=0. Each x SHALL equal DC_POLICY.
REQ-018 The output stage SHALL be a 2-state FSM: EMPTY (jk_valid=0) and FULL (jk_valid=1).
REQ-019 tgt_ready SHALL equal (state==EMPTY || jk_ready) && !sync_valid.
REQ-020 A target SHALL be accepted when tgt_valid && tgt_ready; j/k/chg_cnt SHALL be registered and valid in the next cycle (latency 1).
REQ-021 The FSM transitions SHALL be:
 - EMPTY->FULL on accept.
 - FULL->EMPTY on jk_ready without accept.
 - FULL->FULL on jk_ready with accept, or while jk_ready=0.
REQ-022 While FULL and jk_ready=0, j, k and chg_cnt SHALL hold stable.
REQ-023 On handshake (jk_valid && jk_ready), q_model SHALL update to the JK next-state function of j/k applied bitwise: 00 hold, 01 clear, 10 set, 11 toggle.
REQ-024 On handshake, xfer_cnt SHALL increment by 1, wrapping 0xFFFF->0.
REQ-025 Excitation for an accepted target SHALL be computed against the post-handshake model value when a handshake occurs in the same cycle (back-to-back throughput of 1 per cycle).
REQ-026 chg_cnt SHALL equal the popcount of (q_model_basis XOR tgt_data) at accept.
REQ-027 sync_valid SHALL have priority over every other event:
 - q_model<=sync_data next cycle.
 - Any FULL entry SHALL be discarded: state->EMPTY, jk_valid=0, no xfer_cnt increment, even if jk_ready=1.
REQ-028 A target equal to q_model SHALL still produce a transfer, with chg_cnt=0.

Reset
REQ-029 On rst, the block SHALL set: q_model=0, j=0, k=0, jk_valid=0, chg_cnt=0, xfer_cnt=0, state=EMPTY.
REQ-030 rst SHALL override sync_valid and any in-flight handshake.
REQ-031 tgt_ready SHALL be 0 during the rst cycle.

Structure
REQ-032 A shared package SHALL hold the FSM state enum (EMPTY, FULL), the DC_POLICY encodings, and the JK next-state function.
REQ-033 The q_model bits SHALL be built as a generate array of sub-module jk_model_cell (one JK bit, synchronous reset, enable = handshake, load = sync).

Verification
REQ-034 Scenario 1: reset, WIDTH=8, DC_POLICY=0, target 0xA5 with jk_ready=1 -> next cycle j=0xA5, k=0x00, chg_cnt=4; after the handshake q_model=0xA5 and xfer_cnt=1.
REQ-035 Scenario 2: from q_model=0xA5, target 0x5A with DC_POLICY=1 -> j=0xFF, k=0xFF, chg_cnt=8; q_model becomes 0x5A.
REQ-036 Scenario 3: jk_ready=0 for 3 cycles after an accept -> tgt_ready=0, j/k stable, xfer_cnt unchanged; then jk_ready=1 -> one increment.
REQ-037 Scenario 4: back-to-back targets 0x01, 0x03, 0x00 with jk_ready held 1 -> one transfer per cycle; j/k for 0x03 computed against 0x01 (j=0x02); final q_model=0x00.
REQ-038 Scenario 5: FULL with jk_ready=1 and sync_valid=1 with sync_data=0x3C -> no increment, jk_valid=0, q_model=0x3C; next target 0x3C -> chg_cnt=0.
REQ-039 Scenario 6: rst asserted while FULL -> all outputs reach their REQ-029 values the next cycle; xfer_cnt wrap checked at 0xFFFF->0.
